// File: rtl/uart_cmd_ctrl.sv
// Frame controller behind the UART receiver: sync hunt, addr/len/payload/XOR checksum, then a burst of register writes.
// Optional ACK request outputs (ack_valid/ack_data) are built only when UART_CMD_ACK_EN is defined.
module uart_cmd_ctrl #(
   parameter int unsigned MAXLEN      = 16,
   parameter int unsigned TIMEOUT_CYC = 50000,
   parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
   input  logic       clk50m,
   input  logic       rst_n,
   input  logic [7:0] rx_data,
   input  logic       rx_ready,
   input  logic       rx_error,
   output logic       wr_en,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       busy,
   output logic       frame_ok,
   output logic       frame_err,
   output logic [2:0] err_code
`ifdef UART_CMD_ACK_EN
   ,
   output logic       ack_valid,
   output logic [7:0] ack_data
`endif
);

   // state | meaning
   // HUNT  | discard bytes until SYNC_BYTE
   // ADDR  | expect start address
   // LEN   | expect payload length (1..MAXLEN)
   // DATA  | buffer payload bytes
   // CHK   | compare XOR checksum
   // WRITE | emit one wr_en per buffered byte, then frame_ok
   typedef enum logic [2:0] {S_HUNT, S_ADDR, S_LEN, S_DATA, S_CHK, S_WRITE} state_t;

   localparam int unsigned IW       = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
   localparam int unsigned TW       = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYC - 1);
   localparam logic [7:0]  MAXLEN_B = 8'(MAXLEN);

   state_t        state_q, state_d;
   logic          rx_ready_q;
   logic [7:0]    addr_q, addr_d;
   logic [7:0]    len_q, len_d;
   logic [7:0]    chk_q, chk_d;
   logic [7:0]    idx_q, idx_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic          wr_en_q, wr_en_d;
   logic [7:0]    wr_addr_q, wr_addr_d;
   logic [7:0]    wr_data_q, wr_data_d;
   logic          busy_q, busy_d;
   logic          frame_ok_q, frame_ok_d;
   logic          frame_err_q, frame_err_d;
   logic [2:0]    err_code_q, err_code_d;
   logic [7:0]    pay_q [0:MAXLEN-1];

   logic          byte_stb;
   logic          pay_we;
   logic          abort;
   logic [2:0]    abort_code;

   assign byte_stb = rx_ready & ~rx_ready_q;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      len_d       = len_q;
      chk_d       = chk_q;
      idx_d       = idx_q;
      tmr_d       = tmr_q;
      wr_en_d     = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      frame_ok_d  = 1'b0;
      frame_err_d = 1'b0;
      err_code_d  = err_code_q;
      pay_we      = 1'b0;
      abort       = 1'b0;
      abort_code  = 3'd0;

      case (state_q)
         S_HUNT: begin
            if (byte_stb && !rx_error && rx_data == SYNC_BYTE) begin
               state_d = S_ADDR;
               tmr_d   = TMR_LOAD;
            end
         end
         S_ADDR, S_LEN, S_DATA, S_CHK: begin
            // A byte on the terminal-count cycle wins over the timeout.
            if (byte_stb) begin
               tmr_d = TMR_LOAD;
               if (rx_error) begin
                  abort      = 1'b1;
                  abort_code = 3'd1;
               end else if (state_q == S_ADDR) begin
                  addr_d  = rx_data;
                  chk_d   = rx_data;
                  state_d = S_LEN;
               end else if (state_q == S_LEN) begin
                  if (rx_data == 8'd0 || rx_data > MAXLEN_B) begin
                     abort      = 1'b1;
                     abort_code = 3'd2;
                  end else begin
                     len_d   = rx_data;
                     chk_d   = chk_q ^ rx_data;
                     idx_d   = 8'd0;
                     state_d = S_DATA;
                  end
               end else if (state_q == S_DATA) begin
                  pay_we = 1'b1;
                  chk_d  = chk_q ^ rx_data;
                  if (idx_q == len_q - 8'd1) state_d = S_CHK;
                  else idx_d = idx_q + 8'd1;
               end else begin
                  if (rx_data == chk_q) begin
                     idx_d   = 8'd0;
                     state_d = S_WRITE;
                  end else begin
                     abort      = 1'b1;
                     abort_code = 3'd3;
                  end
               end
            end else if (tmr_q == '0) begin
               abort      = 1'b1;
               abort_code = 3'd4;
            end else begin
               tmr_d = tmr_q - TW'(1);
            end
         end
         S_WRITE: begin
            if (idx_q == len_q) begin
               frame_ok_d = 1'b1;
               err_code_d = 3'd0;
               state_d    = S_HUNT;
            end else begin
               wr_en_d   = 1'b1;
               wr_addr_d = addr_q + idx_q;
               wr_data_d = pay_q[idx_q[IW-1:0]];
               idx_d     = idx_q + 8'd1;
            end
         end
         default: state_d = S_HUNT;
      endcase

      if (abort) begin
         frame_err_d = 1'b1;
         err_code_d  = abort_code;
         state_d     = S_HUNT;
      end

      busy_d = (state_d != S_HUNT);
   end

   always_ff @(posedge clk50m or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_HUNT;
         rx_ready_q  <= 1'b1;
         addr_q      <= 8'd0;
         len_q       <= 8'd0;
         chk_q       <= 8'd0;
         idx_q       <= 8'd0;
         tmr_q       <= '0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= 8'd0;
         wr_data_q   <= 8'd0;
         busy_q      <= 1'b0;
         frame_ok_q  <= 1'b0;
         frame_err_q <= 1'b0;
         err_code_q  <= 3'd0;
      end else begin
         state_q     <= state_d;
         rx_ready_q  <= rx_ready;
         addr_q      <= addr_d;
         len_q       <= len_d;
         chk_q       <= chk_d;
         idx_q       <= idx_d;
         tmr_q       <= tmr_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         busy_q      <= busy_d;
         frame_ok_q  <= frame_ok_d;
         frame_err_q <= frame_err_d;
         err_code_q  <= err_code_d;
      end
   end

   // Payload buffer holds no reset; it is always written before it is read.
   always_ff @(posedge clk50m) begin
      if (pay_we) pay_q[idx_q[IW-1:0]] <= rx_data;
   end

   assign wr_en     = wr_en_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign busy      = busy_q;
   assign frame_ok  = frame_ok_q;
   assign frame_err = frame_err_q;
   assign err_code  = err_code_q;

`ifdef UART_CMD_ACK_EN
   logic       ack_valid_q, ack_valid_d;
   logic [7:0] ack_data_q, ack_data_d;

   always_comb begin
      ack_valid_d = frame_ok_q | frame_err_q;
      ack_data_d  = ack_data_q;
      if (frame_ok_q) ack_data_d = 8'h06;
      else if (frame_err_q) ack_data_d = 8'h15;
   end

   always_ff @(posedge clk50m or negedge rst_n) begin
      if (!rst_n) begin
         ack_valid_q <= 1'b0;
         ack_data_q  <= 8'd0;
      end else begin
         ack_valid_q <= ack_valid_d;
         ack_data_q  <= ack_data_d;
      end
   end

   assign ack_valid = ack_valid_q;
   assign ack_data  = ack_data_q;
`endif

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: frame table plus timeout and reset-during-write sequences.
module tb_uart_cmd_ctrl;

   localparam int TO = 1000;

   logic       clk50m = 1'b0;
   logic       rst_n;
   logic [7:0] rx_data;
   logic       rx_ready;
   logic       rx_error;
   logic       wr_en;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic       busy;
   logic       frame_ok;
   logic       frame_err;
   logic [2:0] err_code;
`ifdef UART_CMD_ACK_EN
   logic       ack_valid;
   logic [7:0] ack_data;
`endif

   int checks   = 0;
   int failures = 0;

   logic [15:0] wr_log[$];
   int          ok_cnt;
   int          err_cnt;
   int          ack_cnt;
   logic [7:0]  ack_last;

   always #10 clk50m = ~clk50m;

   uart_cmd_ctrl #(.MAXLEN(16), .TIMEOUT_CYC(TO), .SYNC_BYTE(8'hA5)) dut (
      .clk50m   (clk50m),
      .rst_n    (rst_n),
      .rx_data  (rx_data),
      .rx_ready (rx_ready),
      .rx_error (rx_error),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .busy     (busy),
      .frame_ok (frame_ok),
      .frame_err(frame_err),
      .err_code (err_code)
`ifdef UART_CMD_ACK_EN
      ,
      .ack_valid(ack_valid),
      .ack_data (ack_data)
`endif
   );

   always @(negedge clk50m) begin
      if (wr_en) wr_log.push_back({wr_addr, wr_data});
      if (frame_ok) ok_cnt++;
      if (frame_err) err_cnt++;
`ifdef UART_CMD_ACK_EN
      if (ack_valid) begin
         ack_cnt++;
         ack_last = ack_data;
      end
`endif
   end

   typedef struct {
      string       name;
      logic [63:0] bytes;    // first byte in the top octet
      int          nb;
      int          err_idx;  // byte sent with rx_error, -1 for none
      int          nwr;
      logic [31:0] exp_w;    // {addr0,data0,addr1,data1}
      int          ok;
      int          err;
      logic [2:0]  code;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_logs();
      @(posedge clk50m);
      wr_log.delete();
      ok_cnt  = 0;
      err_cnt = 0;
      ack_cnt = 0;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic e);
      @(negedge clk50m);
      rx_data  = b;
      rx_error = e;
      rx_ready = 1'b1;
      repeat (2) @(negedge clk50m);
      rx_ready = 1'b0;
      rx_error = 1'b0;
      repeat (3) @(negedge clk50m);
   endtask

   task automatic run_vec(input vec_t v);
      logic [63:0] b;
      clear_logs();
      b = v.bytes;
      for (int i = 0; i < v.nb; i++) send_byte(b[63-8*i -: 8], (i == v.err_idx));
      repeat (30) @(negedge clk50m);
      check({v.name, "/nwr"}, wr_log.size(), v.nwr);
      if (v.nwr >= 1 && wr_log.size() >= 1) check({v.name, "/w0"}, wr_log[0], v.exp_w[31:16]);
      if (v.nwr >= 2 && wr_log.size() >= 2) check({v.name, "/w1"}, wr_log[1], v.exp_w[15:0]);
      check({v.name, "/ok"}, ok_cnt, v.ok);
      check({v.name, "/err"}, err_cnt, v.err);
      check({v.name, "/code"}, err_code, v.code);
      check({v.name, "/busy"}, busy, 0);
`ifdef UART_CMD_ACK_EN
      check({v.name, "/ack_cnt"}, ack_cnt, v.ok + v.err);
      if (v.ok == 1) check({v.name, "/ack"}, ack_last, 8'h06);
      if (v.err == 1) check({v.name, "/ack"}, ack_last, 8'h15);
`endif
   endtask

   initial begin
      int cyc;
      int nw;
      logic seen;

      vecs[0] = '{"good",      {8'hA5,8'h10,8'h02,8'h11,8'h22,8'h21,16'h0}, 6, -1, 2, 32'h1011_1122, 1, 0, 3'd0};
      vecs[1] = '{"bad_chk",   {8'hA5,8'h10,8'h02,8'h11,8'h22,8'h20,16'h0}, 6, -1, 0, 32'h0,         0, 1, 3'd3};
      vecs[2] = '{"good2",     {8'hA5,8'h10,8'h02,8'h11,8'h22,8'h21,16'h0}, 6, -1, 2, 32'h1011_1122, 1, 0, 3'd0};
      vecs[3] = '{"len0",      {8'hA5,8'h10,8'h00,40'h0},                   3, -1, 0, 32'h0,         0, 1, 3'd2};
      vecs[4] = '{"len17",     {8'hA5,8'h10,8'h11,40'h0},                   3, -1, 0, 32'h0,         0, 1, 3'd2};
      // FF^02^AA^BB is 0xEC, so a trailing 0xEE is a checksum failure.
      vecs[5] = '{"wrap_bad",  {8'hA5,8'hFF,8'h02,8'hAA,8'hBB,8'hEE,16'h0}, 6, -1, 0, 32'h0,         0, 1, 3'd3};
      vecs[6] = '{"wrap",      {8'h00,8'hFF,8'hA5,8'hFF,8'h02,8'hAA,8'hBB,8'hEC}, 8, -1, 2, 32'hFFAA_00BB, 1, 0, 3'd0};
      vecs[7] = '{"uart_err",  {8'hA5,8'h10,8'h02,8'h11,32'h0},             4,  2, 0, 32'h0,         0, 1, 3'd1};
      vecs[8] = '{"hunt_err",  {8'hA5,8'hA5,8'h10,8'h01,8'h33,8'h22,16'h0}, 6,  0, 1, 32'h1033_0000, 1, 0, 3'd0};

      // Reset with rx_ready already high: no byte may be taken on release.
      rst_n    = 1'b0;
      rx_data  = 8'hA5;
      rx_ready = 1'b1;
      rx_error = 1'b0;
      ok_cnt   = 0;
      err_cnt  = 0;
      ack_cnt  = 0;
      ack_last = 8'h00;
      repeat (3) @(negedge clk50m);
      check("rst/wr_en", wr_en, 0);
      check("rst/outs", {wr_addr, wr_data, frame_ok, frame_err, err_code}, 0);
      check("rst/busy", busy, 0);
`ifdef UART_CMD_ACK_EN
      check("rst/ack", {ack_valid, ack_data}, 0);
`endif
      rst_n = 1'b1;
      repeat (5) @(negedge clk50m);
      check("rst_rel/busy", busy, 0);
      rx_ready = 1'b0;
      repeat (3) @(negedge clk50m);

      for (int i = 0; i < 9; i++) run_vec(vecs[i]);

      // Timeout: frame_err rises TO edges after the edge that takes the 0x11 byte.
      clear_logs();
      send_byte(8'hA5, 1'b0);
      send_byte(8'h10, 1'b0);
      send_byte(8'h02, 1'b0);
      @(negedge clk50m);
      rx_data  = 8'h11;
      rx_ready = 1'b1;
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < TO + 20) begin
         @(negedge clk50m);
         cyc++;
         if (cyc == 2) rx_ready = 1'b0;
         if (frame_err) seen = 1'b1;
      end
      check("timeout/cycles", cyc, TO + 1);
      @(negedge clk50m);
      check("timeout/code", err_code, 3'd4);
      check("timeout/busy", busy, 0);
      check("timeout/nwr", wr_log.size(), 0);

      // Reset after the third write of an 8-byte frame (chk = 20^08^01^..^08 = 0x20).
      clear_logs();
      send_byte(8'hA5, 1'b0);
      send_byte(8'h20, 1'b0);
      send_byte(8'h08, 1'b0);
      for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b0);
      @(negedge clk50m);
      rx_data  = 8'h20;
      rx_ready = 1'b1;
      nw  = 0;
      cyc = 0;
      while (nw < 3 && cyc < 20) begin
         @(negedge clk50m);
         cyc++;
         if (wr_en) nw++;
      end
      check("rstw/reached3", nw, 3);
      rst_n = 1'b0;
      #1;
      check("rstw/wr_en", wr_en, 0);
      check("rstw/busy", busy, 0);
      repeat (2) @(negedge clk50m);
      rst_n = 1'b1;
      repeat (20) @(negedge clk50m);
      check("rstw/busy_after", busy, 0);
      check("rstw/nwr", wr_log.size(), 3);
      if (wr_log.size() >= 3) check("rstw/w2", wr_log[2], 16'h2203);
      check("rstw/ok", ok_cnt, 0);
      rx_ready = 1'b0;
      repeat (3) @(negedge clk50m);

      run_vec(vecs[0]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
